forward_y_stage: RTL and testbench
==================================

// Module: forward_y_stage
// PURPOSE
//  Registered, parametrised successor to the combinational north/local forwarder.
//  - Buffers incoming packets in an input FIFO.
//  - Decodes the Y offset field (dy) of the head packet.
//  - Steers the packet to NORTH (dy>0), SOUTH (dy<0) or LOCAL (dy==0), each with valid/ready.
//  - Rewrites dy by one hop toward zero on NORTH/SOUTH.
//  Sits on the Y-dimension path of each router tile, after X routing.
// PARAMETERS
//  PKT_W      16  packet width in bits
//  DY_LSB     8   LSB of dy field in packet
//  DY_W       4   dy field width
//  DEPTH      4   input FIFO entries (power of 2, >=2)
//  SIGNED_DY  1   1: dy two's complement, enables SOUTH; 0: dy unsigned, SOUTH never used
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          synchronous reset, active-high
//  in_packet     in   PKT_W      packet from upstream
//  in_valid      in   1          in_packet valid
//  in_ready      out  1          FIFO can accept (= !full)
//  north_packet  out  PKT_W      packet to north, dy decremented
//  north_valid   out  1          north_packet valid
//  north_ready   in   1          north consumer accepts
//  south_packet  out  PKT_W      packet to south, dy incremented
//  south_valid   out  1
//  south_ready   in   1
//  local_packet  out  PKT_W      packet to local port, unmodified
//  local_valid   out  1
//  local_ready   in   1
//  fifo_count    out  log2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): FIFO pointers/count=0, all *_valid=0, *_packet=0, in_ready=1 after reset.
//    - in_valid ignored while rst=1.
//    - Mid-operation reset discards all buffered and output-held packets without completing them.
//  - Handshake: transfer on any port when valid&&ready at a rising edge.
//    - valid, once high, stays high with packet stable until accepted.
//    - in_ready = !full; a pop in the same cycle does NOT raise in_ready (no write-through-full).
//  - Write: in_valid&&in_ready pushes in_packet at edge. Push and pop in the same cycle: count unchanged.
//  - Decode: head dy = packet[DY_LSB+DY_W-1:DY_LSB].
//    - SIGNED_DY=1: sign bit set -> SOUTH; nonzero positive -> NORTH; zero -> LOCAL.
//    - SIGNED_DY=0: nonzero -> NORTH; zero -> LOCAL; south_valid tied 0, south_packet tied 0.
//  - Output stage: one holding register per port.
//    - Head pops at edge iff FIFO non-empty and target register is empty or being accepted that edge.
//    - Pop loads the target register and sets its valid.
//    - An accepted register with no new load clears its valid.
//  - Rewrite: NORTH dy-1, SOUTH dy+1, DY_W-bit modular; cannot wrap because the sign is known.
//    Other bits pass through unchanged.
//  - Latency: input accepted at edge k -> output valid from edge k+1 with FIFO empty and target free.
//    Throughput 1 packet/cycle when the target port is ready.
//  - Ordering: strict FIFO order; head-of-line blocking accepted.
//    A packet for a blocked port stalls all packets behind it, even if their port is free.
//  - Full: count==DEPTH -> in_ready=0. Empty: no pop, output regs hold or drain normally.
//  - Total storage = DEPTH + 3 (one per output register).
// STRUCTURE
//  - router_pkg: PKT_W, DY_LSB, DY_W defaults; port enum {DIR_LOCAL, DIR_NORTH, DIR_SOUTH};
//    function dy_decode(dy, signed_mode) -> dir; function dy_step(dy, dir) -> new dy.
//  - Sub-module sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count, synchronous active-high rst.
//    Reused by future X-stage.
//  - Top: decode + pop arbitration + three output registers. No other state.
// TESTING (PKT_W=16, DY_LSB=8, DY_W=4, DEPTH=4, SIGNED_DY=1, all readys=1 unless stated)
//  1. in 16'h0200 one cycle -> next cycle north_valid=1, north_packet=16'h0100; other valids 0.
//  2. in 16'h0000 -> local_valid=1, local_packet=16'h0000 one cycle after accept.
//  3. in 16'h0E00 (dy=-2) -> south_packet=16'h0F00; then 16'h0F00 -> south_packet=16'h0000.
//  4. north_ready=0, stream 16'h0300 every cycle:
//     - 5 accepted (1 in reg + 4 FIFO), then in_ready=0, fifo_count=4.
//     - Raise north_ready: one packet/cycle out in order, in_ready=1 one cycle after first pop.
//  5. HOL: north_ready=0, send 16'h0100 then 16'h0000:
//     - local_valid stays 0 until north accepted; then local_packet=16'h0000 next cycle.
//  6. Reset with fifo_count=3 and north_valid=1: after edge all valids 0, fifo_count=0, in_ready=1.
//     Next packet 16'h0000 routes normally. Repeat 1-2 with SIGNED_DY=0: 16'h0E00 -> north 16'h0D00.

Source files
------------

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router tile datapath stages.
//   DEF_PKT_W / DEF_DY_LSB / DEF_DY_W : default packet geometry
//   dir_e                             : output port selector for a routing stage
//   dy_decode()                       : Y offset -> output port
//   dy_step()                         : Y offset after one hop toward zero
// The helpers take the offset zero-extended to 32 bits plus its real width, so
// every stage can use them whatever dy width it is built with.
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int DEF_PKT_W  = 16;
    localparam int DEF_DY_LSB = 8;
    localparam int DEF_DY_W   = 4;

    typedef enum logic [1:0] {
        DIR_LOCAL = 2'd0,
        DIR_NORTH = 2'd1,
        DIR_SOUTH = 2'd2
    } dir_e;

    // Zero offset stays local. A set sign bit means "go south" only when the
    // field is two's complement; an unsigned field is never negative.
    function automatic dir_e dy_decode(input logic [31:0] dy,
                                       input int unsigned dy_w,
                                       input logic        signed_mode);
        dir_e dir;
        dir = DIR_LOCAL;
        if (dy != 32'd0) begin
            if (signed_mode && (((dy >> (dy_w - 1)) & 32'd1) != 32'd0))
                dir = DIR_SOUTH;
            else
                dir = DIR_NORTH;
        end
        return dir;
    endfunction

    // One hop toward zero. The caller keeps the low dy_w bits, which gives the
    // dy_w-bit modular result; the direction already tells us no wrap occurs.
    function automatic logic [31:0] dy_step(input logic [31:0] dy,
                                            input dir_e        dir);
        logic [31:0] nxt;
        case (dir)
            DIR_NORTH: nxt = dy - 32'd1;
            DIR_SOUTH: nxt = dy + 32'd1;
            default:   nxt = dy;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through read data.
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high (empties the FIFO)
//   i_push   in   write i_data this edge (ignored when full)
//   i_data   in   WIDTH-bit write data
//   i_pop    in   drop the head entry this edge (ignored when empty)
//   o_data   out  head entry, valid whenever !o_empty
//   o_full   out  count == DEPTH
//   o_empty  out  count == 0
//   o_count  out  occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the count alone decides which entries are
    // live, and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/forward_y_stage.sv
// -----------------------------------------------------------------------------
// forward_y_stage
// Y-dimension forwarding stage of a router tile, placed after X routing.
// Packets are queued in an input FIFO; the head is steered by its dy field to
// NORTH (dy>0), SOUTH (dy<0, signed mode only) or LOCAL (dy==0), with dy moved
// one hop toward zero on NORTH/SOUTH. Each output has one holding register.
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_packet/valid/ready    upstream input; in_ready = FIFO not full
//   north_packet/valid/ready north output, dy decremented
//   south_packet/valid/ready south output, dy incremented (tied 0 if unsigned)
//   local_packet/valid/ready local output, packet unmodified
//   fifo_count               input FIFO occupancy
// Ordering is strict FIFO: a head waiting on a busy port blocks everything
// behind it.
// -----------------------------------------------------------------------------
module forward_y_stage
    import router_pkg::*;
#(
    parameter int PKT_W     = DEF_PKT_W,
    parameter int DY_LSB    = DEF_DY_LSB,
    parameter int DY_W      = DEF_DY_W,
    parameter int DEPTH     = 4,
    parameter bit SIGNED_DY = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PKT_W-1:0]       in_packet,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [PKT_W-1:0]       north_packet,
    output logic                   north_valid,
    input  logic                   north_ready,
    output logic [PKT_W-1:0]       south_packet,
    output logic                   south_valid,
    input  logic                   south_ready,
    output logic [PKT_W-1:0]       local_packet,
    output logic                   local_valid,
    input  logic                   local_ready,
    output logic [$clog2(DEPTH):0] fifo_count
);

    logic [PKT_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [DY_W-1:0]  w_head_dy;
    dir_e             w_dir;
    logic [PKT_W-1:0] w_out_pkt;
    logic             w_target_free;

    logic [PKT_W-1:0] r_north_pkt;
    logic [PKT_W-1:0] r_south_pkt;
    logic [PKT_W-1:0] r_local_pkt;
    logic             r_north_valid;
    logic             r_south_valid;
    logic             r_local_valid;

    // A pop in the same cycle does not open in_ready: no write-through-full.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;

    sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_packet),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign w_head_dy = w_head[DY_LSB +: DY_W];
    assign w_dir     = dy_decode(32'(w_head_dy), DY_W, SIGNED_DY);

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_out_pkt                 = w_head;
        w_out_pkt[DY_LSB +: DY_W] = DY_W'(dy_step(32'(w_head_dy), w_dir));
    end

    // The head may move when its target register is empty or is handing its
    // packet over at this same edge.
    always_comb begin
        w_target_free = 1'b0;
        case (w_dir)
            DIR_NORTH: w_target_free = !r_north_valid || north_ready;
            DIR_SOUTH: w_target_free = !r_south_valid || south_ready;
            default:   w_target_free = !r_local_valid || local_ready;
        endcase
    end

    assign w_pop = !w_empty && w_target_free;

    // Output holding registers: a load wins over an accept, so a register can
    // hand one packet off and take the next at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_north_valid <= 1'b0;
            r_north_pkt   <= '0;
        end else if (w_pop && (w_dir == DIR_NORTH)) begin
            r_north_valid <= 1'b1;
            r_north_pkt   <= w_out_pkt;
        end else if (north_ready) begin
            r_north_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_south_valid <= 1'b0;
            r_south_pkt   <= '0;
        end else if (w_pop && (w_dir == DIR_SOUTH)) begin
            r_south_valid <= 1'b1;
            r_south_pkt   <= w_out_pkt;
        end else if (south_ready) begin
            r_south_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_local_valid <= 1'b0;
            r_local_pkt   <= '0;
        end else if (w_pop && (w_dir == DIR_LOCAL)) begin
            r_local_valid <= 1'b1;
            r_local_pkt   <= w_out_pkt;
        end else if (local_ready) begin
            r_local_valid <= 1'b0;
        end
    end

    assign north_packet = r_north_pkt;
    assign north_valid  = r_north_valid;
    assign local_packet = r_local_pkt;
    assign local_valid  = r_local_valid;

    // With an unsigned dy the decoder never selects SOUTH; the port is tied off.
    assign south_packet = SIGNED_DY ? r_south_pkt : '0;
    assign south_valid  = SIGNED_DY ? r_south_valid : 1'b0;

endmodule

// File: tb/tb_forward_y_stage.sv
// -----------------------------------------------------------------------------
// tb_forward_y_stage
// Two instances share clk/rst: dut_a with signed dy, dut_b with unsigned dy.
// Stimulus pushes the hand-computed output packet into a per-port queue,
// indexed {dut, dir}; a negedge monitor pops and compares on every transfer.
// -----------------------------------------------------------------------------
module tb_forward_y_stage;
    import router_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [15:0] a_in_packet, a_north_packet, a_south_packet, a_local_packet;
    logic        a_in_valid, a_in_ready;
    logic        a_north_valid, a_north_ready;
    logic        a_south_valid, a_south_ready;
    logic        a_local_valid, a_local_ready;
    logic [2:0]  a_fifo_count;

    logic [15:0] b_in_packet, b_north_packet, b_south_packet, b_local_packet;
    logic        b_in_valid, b_in_ready;
    logic        b_north_valid, b_north_ready;
    logic        b_south_valid, b_south_ready;
    logic        b_local_valid, b_local_ready;
    logic [2:0]  b_fifo_count;

    forward_y_stage #(
        .PKT_W(16), .DY_LSB(8), .DY_W(4), .DEPTH(4), .SIGNED_DY(1'b1)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .in_packet    (a_in_packet),
        .in_valid     (a_in_valid),
        .in_ready     (a_in_ready),
        .north_packet (a_north_packet),
        .north_valid  (a_north_valid),
        .north_ready  (a_north_ready),
        .south_packet (a_south_packet),
        .south_valid  (a_south_valid),
        .south_ready  (a_south_ready),
        .local_packet (a_local_packet),
        .local_valid  (a_local_valid),
        .local_ready  (a_local_ready),
        .fifo_count   (a_fifo_count)
    );

    forward_y_stage #(
        .PKT_W(16), .DY_LSB(8), .DY_W(4), .DEPTH(4), .SIGNED_DY(1'b0)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .in_packet    (b_in_packet),
        .in_valid     (b_in_valid),
        .in_ready     (b_in_ready),
        .north_packet (b_north_packet),
        .north_valid  (b_north_valid),
        .north_ready  (b_north_ready),
        .south_packet (b_south_packet),
        .south_valid  (b_south_valid),
        .south_ready  (b_south_ready),
        .local_packet (b_local_packet),
        .local_valid  (b_local_valid),
        .local_ready  (b_local_ready),
        .fifo_count   (b_fifo_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected packets per output port, index {dut, dir}.
    logic [15:0] q [8][$];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic mon(input logic [2:0] idx, input string name,
                       input logic v, input logic r, input logic [15:0] pkt);
        if (v && r) begin
            if (q[idx].size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: got unexpected packet %0h, expected none", name, pkt);
            end else begin
                check(name, pkt, q[idx].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon({1'b0, DIR_LOCAL}, "a_local", a_local_valid, a_local_ready, a_local_packet);
            mon({1'b0, DIR_NORTH}, "a_north", a_north_valid, a_north_ready, a_north_packet);
            mon({1'b0, DIR_SOUTH}, "a_south", a_south_valid, a_south_ready, a_south_packet);
            mon({1'b1, DIR_LOCAL}, "b_local", b_local_valid, b_local_ready, b_local_packet);
            mon({1'b1, DIR_NORTH}, "b_north", b_north_valid, b_north_ready, b_north_packet);
            mon({1'b1, DIR_SOUTH}, "b_south", b_south_valid, b_south_ready, b_south_packet);
        end
    end

    function automatic int pending();
        return q[0].size() + q[1].size() + q[2].size()
             + q[4].size() + q[5].size() + q[6].size();
    endfunction

    // Offer one packet; hold valid until accepted (bounded), then record
    // the expected output when track is set.
    task automatic send(input bit dut, input logic [15:0] pkt, input dir_e dir,
                        input logic [15:0] exp, input bit track);
        bit acc;
        int waited;
        waited = 0;
        if (dut) begin b_in_packet = pkt; b_in_valid = 1'b1; end
        else     begin a_in_packet = pkt; a_in_valid = 1'b1; end
        do begin
            acc = dut ? b_in_ready : a_in_ready;
            @(posedge clk); #1;
            waited++;
        end while (!acc && waited < 20);
        if (dut) b_in_valid = 1'b0;
        else     a_in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: packet %0h never accepted, expected accept", pkt);
        end else if (track) begin
            q[{dut, dir}].push_back(exp);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (pending() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending", 16'(pending()), 16'd0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        a_in_packet = 16'h0; a_in_valid = 1'b0;
        b_in_packet = 16'h0; b_in_valid = 1'b0;
        a_north_ready = 1'b1; a_south_ready = 1'b1; a_local_ready = 1'b1;
        b_north_ready = 1'b1; b_south_ready = 1'b1; b_local_ready = 1'b1;
        repeat (2) step();

        // Reset state
        check("rst_in_ready",    16'(a_in_ready),    16'd1);
        check("rst_fifo_count",  16'(a_fifo_count),  16'd0);
        check("rst_north_valid", 16'(a_north_valid), 16'd0);
        check("rst_south_valid", 16'(a_south_valid), 16'd0);
        check("rst_local_valid", 16'(a_local_valid), 16'd0);
        check("rst_north_pkt",   a_north_packet,     16'h0000);
        check("rst_b_in_ready",  16'(b_in_ready),    16'd1);
        rst = 1'b0;

        // 1: north, one-cycle latency, dy 2 -> 1
        send(1'b0, 16'h0200, DIR_NORTH, 16'h0100, 1'b1);
        step();
        check("t1_north_valid", 16'(a_north_valid), 16'd1);
        check("t1_local_valid", 16'(a_local_valid), 16'd0);
        check("t1_south_valid", 16'(a_south_valid), 16'd0);

        // 2: local, unmodified
        send(1'b0, 16'h0000, DIR_LOCAL, 16'h0000, 1'b1);
        step();
        check("t2_local_valid", 16'(a_local_valid), 16'd1);

        // 3: south, dy -2 -> -1, then -1 -> 0
        send(1'b0, 16'h0E00, DIR_SOUTH, 16'h0F00, 1'b1);
        send(1'b0, 16'h0F00, DIR_SOUTH, 16'h0000, 1'b1);
        drain();

        // 4: north blocked, continuous stream fills register + FIFO
        a_north_ready = 1'b0;
        a_in_packet   = 16'h0300;
        a_in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_in_ready_open", 16'(a_in_ready), 16'd1);
            q[{1'b0, DIR_NORTH}].push_back(16'h0200);
            step();
        end
        check("t4_in_ready_full", 16'(a_in_ready),    16'd0);
        check("t4_count_full",    16'(a_fifo_count),  16'd4);
        check("t4_north_held",    16'(a_north_valid), 16'd1);
        step();
        check("t4_in_ready_stall", 16'(a_in_ready), 16'd0);
        a_north_ready = 1'b1;
        step();
        check("t4_in_ready_reopen", 16'(a_in_ready),   16'd1);
        check("t4_count_after_pop", 16'(a_fifo_count), 16'd3);
        a_in_valid = 1'b0;
        for (int c = 2; c >= 0; c--) begin
            step();
            check("t4_count_drain", 16'(a_fifo_count), 16'(c));
        end
        drain();

        // 5: head-of-line blocking behind a busy north port
        a_north_ready = 1'b0;
        send(1'b0, 16'h0100, DIR_NORTH, 16'h0000, 1'b1);
        send(1'b0, 16'h0200, DIR_NORTH, 16'h0100, 1'b1);
        send(1'b0, 16'h0000, DIR_LOCAL, 16'h0000, 1'b1);
        repeat (3) step();
        check("t5_local_blocked", 16'(a_local_valid), 16'd0);
        check("t5_north_held",    16'(a_north_valid), 16'd1);
        check("t5_count",         16'(a_fifo_count),  16'd2);
        a_north_ready = 1'b1;
        step();
        check("t5_local_still_blocked", 16'(a_local_valid), 16'd0);
        step();
        check("t5_local_released", 16'(a_local_valid), 16'd1);
        check("t5_north_done",     16'(a_north_valid), 16'd0);
        drain();

        // 6: mid-operation reset discards everything; in_valid ignored in reset
        a_north_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 16'h0100, DIR_NORTH, 16'h0000, 1'b0);
        check("t6_count_pre",  16'(a_fifo_count),  16'd3);
        check("t6_north_pre",  16'(a_north_valid), 16'd1);
        rst         = 1'b1;
        a_in_packet = 16'h0000;
        a_in_valid  = 1'b1;
        step();
        check("t6_north_valid", 16'(a_north_valid), 16'd0);
        check("t6_local_valid", 16'(a_local_valid), 16'd0);
        check("t6_south_valid", 16'(a_south_valid), 16'd0);
        check("t6_count",       16'(a_fifo_count),  16'd0);
        check("t6_in_ready",    16'(a_in_ready),    16'd1);
        check("t6_north_pkt",   a_north_packet,     16'h0000);
        step();
        check("t6_in_valid_ignored", 16'(a_fifo_count), 16'd0);
        rst           = 1'b0;
        a_in_valid    = 1'b0;
        a_north_ready = 1'b1;
        send(1'b0, 16'h0000, DIR_LOCAL, 16'h0000, 1'b1);
        step();
        check("t6_post_local_valid", 16'(a_local_valid), 16'd1);
        drain();

        // Unsigned dy: everything nonzero goes north, south tied off
        send(1'b1, 16'h0200, DIR_NORTH, 16'h0100, 1'b1);
        step();
        check("u1_north_valid", 16'(b_north_valid), 16'd1);
        send(1'b1, 16'h0000, DIR_LOCAL, 16'h0000, 1'b1);
        send(1'b1, 16'h0E00, DIR_NORTH, 16'h0D00, 1'b1);
        step();
        check("u3_south_valid", 16'(b_south_valid), 16'd0);
        check("u3_south_pkt",   b_south_packet,     16'h0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
